// File: rtl/adxl362_scan_sequencer.sv
// Register-scan engine in front of the single-byte adxl362_controller.
//
// Periodically reads NUM_CHANNELS channels of BYTES_PER_CHANNEL bytes each and publishes them
// atomically on `samples` (one-cycle `samples_valid`). One-shot manual read/write requests are
// held in a depth-1 register and slotted in between scan bytes, never aborting a transfer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   scan_enable                enables the periodic scan timer
//   man_req/write/addr/wdata   manual request (one-cycle req pulse)
//   man_ack, man_done          request accepted / transfer complete pulses
//   man_rdata                  last manual read byte
//   ctrl_start/write/addr/wdata  command to the byte controller
//   ctrl_busy/done/rdata       controller status and read data
//   samples, samples_valid     published scan vector and its update pulse
//   scan_overrun               sticky: scan tick while a scan was pending or active
//   busy                       sequencer not idle
module adxl362_scan_sequencer #(
  parameter int unsigned CLK_FREQUENCY     = 100_000_000,
  parameter int unsigned SCAN_RATE         = 2,
  parameter int unsigned NUM_CHANNELS      = 3,
  parameter int unsigned BYTES_PER_CHANNEL = 1,
  parameter logic [63:0] CHANNEL_ADDRS     = 64'h0000_0000_000A_0908
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        scan_enable,
  input  logic                                        man_req,
  input  logic                                        man_write,
  input  logic [7:0]                                  man_addr,
  input  logic [7:0]                                  man_wdata,
  output logic                                        man_ack,
  output logic                                        man_done,
  output logic [7:0]                                  man_rdata,
  output logic                                        ctrl_start,
  output logic                                        ctrl_write,
  output logic [7:0]                                  ctrl_addr,
  output logic [7:0]                                  ctrl_wdata,
  input  logic                                        ctrl_busy,
  input  logic                                        ctrl_done,
  input  logic [7:0]                                  ctrl_rdata,
  output logic [NUM_CHANNELS*BYTES_PER_CHANNEL*8-1:0] samples,
  output logic                                        samples_valid,
  output logic                                        scan_overrun,
  output logic                                        busy
);

  localparam int unsigned ScanPeriod = CLK_FREQUENCY / SCAN_RATE;
  localparam int unsigned CntW       = (ScanPeriod > 1) ? $clog2(ScanPeriod) : 1;
  localparam int unsigned TotalBytes = NUM_CHANNELS * BYTES_PER_CHANNEL;
  localparam int unsigned IdxW       = $clog2(TotalBytes + 1);
  localparam int unsigned SampleW    = TotalBytes * 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StPublish} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 scan_pending_q, scan_pending_d;
  logic                 scan_overrun_q, scan_overrun_d;
  logic                 scan_active_q, scan_active_d;
  logic                 cur_man_q, cur_man_d;
  logic [IdxW-1:0]      byte_idx_q, byte_idx_d;
  logic                 hold_full_q, hold_full_d;
  logic                 hold_write_q, hold_write_d;
  logic [7:0]           hold_addr_q, hold_addr_d;
  logic [7:0]           hold_wdata_q, hold_wdata_d;
  logic [SampleW-1:0]   shadow_q, shadow_d;
  logic [SampleW-1:0]   samples_q, samples_d;
  logic                 samples_valid_q, samples_valid_d;
  logic                 man_ack_q, man_ack_d;
  logic                 man_done_q, man_done_d;
  logic [7:0]           man_rdata_q, man_rdata_d;
  logic                 ctrl_start_q, ctrl_start_d;
  logic                 ctrl_write_q, ctrl_write_d;
  logic [7:0]           ctrl_addr_q, ctrl_addr_d;
  logic [7:0]           ctrl_wdata_q, ctrl_wdata_d;
  logic                 busy_q, busy_d;

  logic       accept;
  logic       man_pending;
  logic       consume;
  logic [7:0] scan_addr;

  // Byte k of the scan is channel k/BPC, offset k%BPC: base address plus offset, 8-bit wrap.
  always_comb begin
    scan_addr = '0;
    for (int k = 0; k < int'(TotalBytes); k++) begin
      if (byte_idx_q == IdxW'(k)) begin
        scan_addr = CHANNEL_ADDRS[8*(k/int'(BYTES_PER_CHANNEL)) +: 8]
                    + 8'(k % int'(BYTES_PER_CHANNEL));
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    scan_pending_d  = scan_pending_q;
    scan_overrun_d  = scan_overrun_q;
    scan_active_d   = scan_active_q;
    cur_man_d       = cur_man_q;
    byte_idx_d      = byte_idx_q;
    hold_full_d     = hold_full_q;
    hold_write_d    = hold_write_q;
    hold_addr_d     = hold_addr_q;
    hold_wdata_d    = hold_wdata_q;
    shadow_d        = shadow_q;
    samples_d       = samples_q;
    samples_valid_d = 1'b0;
    man_ack_d       = 1'b0;
    man_done_d      = 1'b0;
    man_rdata_d     = man_rdata_q;
    ctrl_start_d    = 1'b0;
    ctrl_write_d    = ctrl_write_q;
    ctrl_addr_d     = ctrl_addr_q;
    ctrl_wdata_d    = ctrl_wdata_q;
    consume         = 1'b0;

    // Depth-1 holding register; a request arriving while full is dropped.
    accept = man_req && !hold_full_q;
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_write_d = man_write;
      hold_addr_d  = man_addr;
      hold_wdata_d = man_wdata;
      man_ack_d    = 1'b1;
    end
    // A request arriving this cycle counts as pending so IDLE can issue it next cycle.
    man_pending = hold_full_q || accept;

    unique case (state_q)
      StIdle: begin
        if (man_pending) begin
          cur_man_d = 1'b1;
          state_d   = StIssue;
        end else if (scan_pending_q) begin
          consume       = 1'b1;
          byte_idx_d    = '0;
          scan_active_d = 1'b1;
          cur_man_d     = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (!ctrl_busy) begin
          ctrl_start_d = 1'b1;
          if (cur_man_q) begin
            ctrl_write_d = hold_write_q;
            ctrl_addr_d  = hold_addr_q;
            ctrl_wdata_d = hold_wdata_q;
          end else begin
            ctrl_write_d = 1'b0;
            ctrl_addr_d  = scan_addr;
            ctrl_wdata_d = 8'h00;
          end
          state_d = StWait;
        end
      end
      StWait: begin
        if (ctrl_done) begin
          if (cur_man_q) begin
            if (!hold_write_q) man_rdata_d = ctrl_rdata;
            man_done_d  = 1'b1;
            hold_full_d = 1'b0;
            cur_man_d   = 1'b0;
            // Resume an interrupted scan at the saved byte index.
            state_d     = scan_active_q ? StIssue : StIdle;
          end else begin
            for (int k = 0; k < int'(TotalBytes); k++) begin
              if (byte_idx_q == IdxW'(k)) shadow_d[8*k +: 8] = ctrl_rdata;
            end
            byte_idx_d = byte_idx_q + IdxW'(1);
            if (byte_idx_q == IdxW'(TotalBytes - 1)) begin
              state_d = StPublish;
            end else begin
              cur_man_d = man_pending;
              state_d   = StIssue;
            end
          end
        end
      end
      StPublish: begin
        samples_d       = shadow_q;
        samples_valid_d = 1'b1;
        scan_active_d   = 1'b0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Scan timer: a tick while a scan is pending or running flags overrun, never queues twice.
    if (!scan_enable) begin
      cnt_d          = '0;
      scan_pending_d = 1'b0;
    end else begin
      if (consume) scan_pending_d = 1'b0;
      if (cnt_q == CntW'(ScanPeriod - 1)) begin
        cnt_d = '0;
        if (scan_pending_q || scan_active_q) scan_overrun_d = 1'b1;
        scan_pending_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      scan_pending_q  <= 1'b0;
      scan_overrun_q  <= 1'b0;
      scan_active_q   <= 1'b0;
      cur_man_q       <= 1'b0;
      byte_idx_q      <= '0;
      hold_full_q     <= 1'b0;
      hold_write_q    <= 1'b0;
      hold_addr_q     <= '0;
      hold_wdata_q    <= '0;
      shadow_q        <= '0;
      samples_q       <= '0;
      samples_valid_q <= 1'b0;
      man_ack_q       <= 1'b0;
      man_done_q      <= 1'b0;
      man_rdata_q     <= '0;
      ctrl_start_q    <= 1'b0;
      ctrl_write_q    <= 1'b0;
      ctrl_addr_q     <= '0;
      ctrl_wdata_q    <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      scan_pending_q  <= scan_pending_d;
      scan_overrun_q  <= scan_overrun_d;
      scan_active_q   <= scan_active_d;
      cur_man_q       <= cur_man_d;
      byte_idx_q      <= byte_idx_d;
      hold_full_q     <= hold_full_d;
      hold_write_q    <= hold_write_d;
      hold_addr_q     <= hold_addr_d;
      hold_wdata_q    <= hold_wdata_d;
      shadow_q        <= shadow_d;
      samples_q       <= samples_d;
      samples_valid_q <= samples_valid_d;
      man_ack_q       <= man_ack_d;
      man_done_q      <= man_done_d;
      man_rdata_q     <= man_rdata_d;
      ctrl_start_q    <= ctrl_start_d;
      ctrl_write_q    <= ctrl_write_d;
      ctrl_addr_q     <= ctrl_addr_d;
      ctrl_wdata_q    <= ctrl_wdata_d;
      busy_q          <= busy_d;
    end
  end

  assign man_ack       = man_ack_q;
  assign man_done      = man_done_q;
  assign man_rdata     = man_rdata_q;
  assign ctrl_start    = ctrl_start_q;
  assign ctrl_write    = ctrl_write_q;
  assign ctrl_addr     = ctrl_addr_q;
  assign ctrl_wdata    = ctrl_wdata_q;
  assign samples       = samples_q;
  assign samples_valid = samples_valid_q;
  assign scan_overrun  = scan_overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adxl362_scan_sequencer.sv
// Bench for adxl362_scan_sequencer: instance A (3 ch x 1 byte, 100-cycle period) and
// instance B (3 ch x 2 bytes, 200-cycle period), each with a simple byte-controller model
// that answers addr ^ salt after a programmable delay.
module tb_adxl362_scan_sequencer;

  localparam logic [63:0] AAddrs = 64'h0000_0000_000A_0908;
  localparam logic [63:0] BAddrs = 64'h0000_0000_0012_100E;

  typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} xfer_t;
  typedef struct {logic w; logic [7:0] addr; logic [7:0] wd; logic [7:0] exp_rdata;} man_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] salt = 8'h55;

  // Instance A signals
  logic a_scan_enable = 0, a_man_req = 0, a_man_write = 0;
  logic [7:0] a_man_addr = 0, a_man_wdata = 0;
  logic a_man_ack, a_man_done, a_ctrl_start, a_ctrl_write, a_samples_valid, a_scan_overrun;
  logic a_busy;
  logic [7:0] a_man_rdata, a_ctrl_addr, a_ctrl_wdata;
  logic [23:0] a_samples;
  logic a_cbusy, a_cdone;
  logic [7:0] a_crdata, a_clat;
  int a_ccnt;
  int a_delay = 20;

  // Instance B signals
  logic b_scan_enable = 0, b_man_req = 0, b_man_write = 0;
  logic [7:0] b_man_addr = 0, b_man_wdata = 0;
  logic b_man_ack, b_man_done, b_ctrl_start, b_ctrl_write, b_samples_valid, b_scan_overrun;
  logic b_busy;
  logic [7:0] b_man_rdata, b_ctrl_addr, b_ctrl_wdata;
  logic [47:0] b_samples;
  logic b_cbusy, b_cdone;
  logic [7:0] b_crdata, b_clat;
  int b_ccnt;

  adxl362_scan_sequencer #(
    .CLK_FREQUENCY(1000), .SCAN_RATE(10), .NUM_CHANNELS(3), .BYTES_PER_CHANNEL(1),
    .CHANNEL_ADDRS(AAddrs)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .scan_enable(a_scan_enable), .man_req(a_man_req),
    .man_write(a_man_write), .man_addr(a_man_addr), .man_wdata(a_man_wdata),
    .man_ack(a_man_ack), .man_done(a_man_done), .man_rdata(a_man_rdata),
    .ctrl_start(a_ctrl_start), .ctrl_write(a_ctrl_write), .ctrl_addr(a_ctrl_addr),
    .ctrl_wdata(a_ctrl_wdata), .ctrl_busy(a_cbusy), .ctrl_done(a_cdone),
    .ctrl_rdata(a_crdata), .samples(a_samples), .samples_valid(a_samples_valid),
    .scan_overrun(a_scan_overrun), .busy(a_busy)
  );

  adxl362_scan_sequencer #(
    .CLK_FREQUENCY(1000), .SCAN_RATE(5), .NUM_CHANNELS(3), .BYTES_PER_CHANNEL(2),
    .CHANNEL_ADDRS(BAddrs)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .scan_enable(b_scan_enable), .man_req(b_man_req),
    .man_write(b_man_write), .man_addr(b_man_addr), .man_wdata(b_man_wdata),
    .man_ack(b_man_ack), .man_done(b_man_done), .man_rdata(b_man_rdata),
    .ctrl_start(b_ctrl_start), .ctrl_write(b_ctrl_write), .ctrl_addr(b_ctrl_addr),
    .ctrl_wdata(b_ctrl_wdata), .ctrl_busy(b_cbusy), .ctrl_done(b_cdone),
    .ctrl_rdata(b_crdata), .samples(b_samples), .samples_valid(b_samples_valid),
    .scan_overrun(b_scan_overrun), .busy(b_busy)
  );

  // Byte-controller models: accept a start when idle, answer addr ^ salt after the delay.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cbusy <= 0; a_cdone <= 0; a_crdata <= 0; a_clat <= 0; a_ccnt <= 0;
    end else begin
      a_cdone <= 0;
      if (a_cbusy) begin
        if (a_ccnt <= 1) begin
          a_cbusy <= 0; a_cdone <= 1; a_crdata <= a_clat ^ salt;
        end else a_ccnt <= a_ccnt - 1;
      end else if (a_ctrl_start) begin
        a_cbusy <= 1; a_ccnt <= a_delay; a_clat <= a_ctrl_addr;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cbusy <= 0; b_cdone <= 0; b_crdata <= 0; b_clat <= 0; b_ccnt <= 0;
    end else begin
      b_cdone <= 0;
      if (b_cbusy) begin
        if (b_ccnt <= 1) begin
          b_cbusy <= 0; b_cdone <= 1; b_crdata <= b_clat ^ salt;
        end else b_ccnt <= b_ccnt - 1;
      end else if (b_ctrl_start) begin
        b_cbusy <= 1; b_ccnt <= 20; b_clat <= b_ctrl_addr;
      end
    end
  end

  // Pulse monitors, sampled mid-cycle.
  xfer_t a_log[$];
  xfer_t b_log[$];
  int a_valid_cnt = 0, a_ack_cnt = 0, a_done_cnt = 0, b_valid_cnt = 0;
  always @(negedge clk) begin
    if (a_ctrl_start) a_log.push_back({a_ctrl_write, a_ctrl_addr, a_ctrl_wdata});
    if (b_ctrl_start) b_log.push_back({b_ctrl_write, b_ctrl_addr, b_ctrl_wdata});
    if (a_samples_valid) a_valid_cnt <= a_valid_cnt + 1;
    if (a_man_ack) a_ack_cnt <= a_ack_cnt + 1;
    if (a_man_done) a_done_cnt <= a_done_cnt + 1;
    if (b_samples_valid) b_valid_cnt <= b_valid_cnt + 1;
  end

  // Reference: byte b of channel i reads (base_i + b) and lands at byte slot i*bpc+b.
  function automatic logic [47:0] expect_samples(input logic [63:0] addrs, input int nch,
                                                 input int bpc, input logic [7:0] s);
    logic [47:0] r;
    logic [7:0] a;
    r = '0;
    for (int i = 0; i < nch; i++)
      for (int b = 0; b < bpc; b++) begin
        a = addrs[i*8 +: 8] + 8'(b);
        r[(i*bpc+b)*8 +: 8] = a ^ s;
      end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_evt(input int sel, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = a_samples_valid;
        1: hit = a_man_done;
        2: hit = b_samples_valid;
        default: hit = a_ctrl_start;
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: got no event in %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic check_a_all_zero(input string name);
    check({name, "_outs"}, {a_man_ack, a_man_done, a_man_rdata, a_ctrl_start, a_ctrl_write,
                            a_ctrl_addr, a_ctrl_wdata, a_samples_valid, a_scan_overrun}, 0);
    check({name, "_samples"}, a_samples, 0);
    check({name, "_busy"}, a_busy, 0);
  endtask

  man_vec_t mv[5];

  initial begin
    int base, v0, ack0, done0;
    logic [47:0] e;
    bit found, hold_empty, req_last;
    xfer_t pend;

    mv[0] = '{w: 0, addr: 8'h00, wd: 8'h00, exp_rdata: 8'h55};
    mv[1] = '{w: 1, addr: 8'h2D, wd: 8'h02, exp_rdata: 8'h55};
    mv[2] = '{w: 0, addr: 8'h0B, wd: 8'h00, exp_rdata: 8'h5E};
    mv[3] = '{w: 1, addr: 8'h1F, wd: 8'hA5, exp_rdata: 8'h5E};
    mv[4] = '{w: 0, addr: 8'hFF, wd: 8'h00, exp_rdata: 8'hAA};

    // Reset state
    repeat (3) @(negedge clk);
    check_a_all_zero("reset_a");
    check("reset_b_samples", {b_samples, b_samples_valid, b_busy, b_scan_overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven manual transfers from idle: ack at +1, start at +2
    for (int i = 0; i < 5; i++) begin
      a_man_req = 1; a_man_write = mv[i].w; a_man_addr = mv[i].addr; a_man_wdata = mv[i].wd;
      @(negedge clk);
      a_man_req = 0;
      check($sformatf("man%0d_ack", i), {a_man_ack, a_ctrl_start, a_busy}, 3'b101);
      @(negedge clk);
      check($sformatf("man%0d_start", i), {a_ctrl_start, a_ctrl_write, a_ctrl_addr},
            {1'b1, mv[i].w, mv[i].addr});
      if (mv[i].w) check($sformatf("man%0d_wdata", i), a_ctrl_wdata, mv[i].wd);
      wait_evt(1, 60, $sformatf("man%0d_done", i));
      check($sformatf("man%0d_rdata", i), a_man_rdata, mv[i].exp_rdata);
      repeat (2) @(negedge clk);
    end

    // Second request while the holding register is full is dropped
    base = a_log.size(); ack0 = a_ack_cnt; done0 = a_done_cnt;
    a_man_req = 1; a_man_write = 0; a_man_addr = 8'h40;
    @(negedge clk);
    check("drop_first_ack", a_man_ack, 1);
    a_man_write = 1; a_man_addr = 8'h41; a_man_wdata = 8'h77;
    @(negedge clk);
    a_man_req = 0;
    check("drop_second_noack", a_man_ack, 0);
    repeat (80) @(negedge clk);
    check("drop_xfers", a_log.size() - base, 1);
    check("drop_addr", a_log[base].a, 8'h40);
    check("drop_acks", a_ack_cnt - ack0, 1);
    check("drop_dones", a_done_cnt - done0, 1);

    // Plain scan, 3 x 1 byte
    base = a_log.size(); v0 = a_valid_cnt;
    a_scan_enable = 1;
    wait_evt(0, 400, "scan_a_valid");
    a_scan_enable = 0;
    check("scan_a_samples", a_samples, 24'h5F5C5D);
    e = expect_samples(AAddrs, 3, 1, salt);
    check("scan_a_model", a_samples, e);
    repeat (150) @(negedge clk);
    check("scan_a_valid_cnt", a_valid_cnt - v0, 1);
    check("scan_a_starts", a_log.size() - base, 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("scan_a_x%0d", k), a_log[base+k], {1'b0, 8'(8'h08 + k), 8'h00});

    // Scan with 2-byte channels
    base = b_log.size(); v0 = b_valid_cnt;
    b_scan_enable = 1;
    wait_evt(2, 600, "scan_b_valid");
    b_scan_enable = 0;
    e = expect_samples(BAddrs, 3, 2, salt);
    check("scan_b_samples", b_samples, e);
    check("scan_b_const", b_samples, 48'h4647_4445_5A5B);
    repeat (250) @(negedge clk);
    check("scan_b_valid_cnt", b_valid_cnt - v0, 1);
    check("scan_b_starts", b_log.size() - base, 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("scan_b_x%0d", k), b_log[base+k], {1'b0, 8'(8'h0E + k), 8'h00});

    // Manual write inserted after byte 1 of a scan; old samples stay visible until publish
    salt = 8'h33;
    base = a_log.size();
    a_scan_enable = 1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = a_ctrl_start && (a_ctrl_addr == 8'h09);
    end
    check("mid_found_byte1", found, 1);
    a_man_req = 1; a_man_write = 1; a_man_addr = 8'h2D; a_man_wdata = 8'h02;
    @(negedge clk);
    a_man_req = 0;
    check("mid_ack", a_man_ack, 1);
    wait_evt(1, 200, "mid_done");
    check("mid_samples_held", {a_samples, a_samples_valid}, {24'h5F5C5D, 1'b0});
    wait_evt(0, 200, "mid_valid");
    a_scan_enable = 0;
    e = expect_samples(AAddrs, 3, 1, salt);
    check("mid_samples", a_samples, e);
    repeat (150) @(negedge clk);
    check("mid_starts", a_log.size() - base, 4);
    check("mid_x0", a_log[base], {1'b0, 8'h08, 8'h00});
    check("mid_x1", a_log[base+1], {1'b0, 8'h09, 8'h00});
    check("mid_x2", a_log[base+2], {1'b1, 8'h2D, 8'h02});
    check("mid_x3", a_log[base+3], {1'b0, 8'h0A, 8'h00});
    check("mid_no_overrun", a_scan_overrun, 0);

    // Randomized manual traffic over running scans, checked against the reference
    hold_empty = 1; req_last = 0; pend = '0;
    a_scan_enable = 1;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (req_last || a_man_ack) check("rand_ack", a_man_ack, req_last);
      if (a_man_done) begin
        check("rand_done_expected", hold_empty, 0);
        if (!pend.w) check("rand_rdata", a_man_rdata, pend.a ^ salt);
        hold_empty = 1;
      end
      if (a_samples_valid) begin
        e = expect_samples(AAddrs, 3, 1, salt);
        check("rand_samples", a_samples, e);
        salt = 8'($urandom_range(0, 255));
      end
      req_last = 0;
      a_man_req = 0;
      if (i == 1600) a_scan_enable = 0;
      if (i < 1600 && hold_empty && $urandom_range(0, 15) == 0) begin
        pend = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        a_man_req = 1; a_man_write = pend.w; a_man_addr = pend.a; a_man_wdata = pend.d;
        hold_empty = 0; req_last = 1;
      end
    end
    check("rand_drained", hold_empty, 1);

    // Asynchronous reset in the middle of a transfer
    a_scan_enable = 1;
    wait_evt(3, 300, "rst_start");
    repeat (5) @(negedge clk);
    a_scan_enable = 0;
    rst_n = 0;
    #1;
    check_a_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("rst_idle", {a_busy, a_ctrl_start}, 0);

    // Slow controller: overrun sets and sticks, pending does not stack up
    a_delay = 150;
    base = a_log.size(); v0 = a_valid_cnt;
    a_scan_enable = 1;
    wait_evt(0, 2000, "ovr_valid");
    a_scan_enable = 0;
    check("ovr_set", a_scan_overrun, 1);
    repeat (700) @(negedge clk);
    check("ovr_sticky", a_scan_overrun, 1);
    check("ovr_valid_cnt", a_valid_cnt - v0, 2);
    check("ovr_starts", a_log.size() - base, 6);
    check("ovr_idle", a_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
